// File: rtl/cache_fill_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : cache_fill_ctrl
//  Purpose  : Two-channel (instruction / data) cache line fill controller.
//             On a miss it latches the line-aligned address, issues one
//             pipelined memory read per word, streams each returning word
//             into the selected cache's data array and finally pulses the
//             tag-array write. Data misses win over instruction misses.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk, rst_n           clock / synchronous active-low reset
//    i_miss, i_miss_addr  instruction-cache miss and its address
//    d_miss, d_miss_addr  data-cache miss and its address
//    i_busy, d_busy       per-channel pipeline stall
//    fsm_busy             controller not idle
//    fill_sel             cache being filled (0 = I, 1 = D)
//    write_data_array     data-array write enable
//    write_word           word index within the line being written
//    write_data           word being written (pass-through of memory_data)
//    write_tag_array      one-cycle tag-array write pulse
//    fill_line_addr       latched line-aligned fill address
//    memory_req           memory read request (one per cycle accepted)
//    memory_address       memory request byte address
//    memory_data          returned memory word
//    memory_data_valid    returned word valid (in request order)
// ============================================================================
module cache_fill_ctrl #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16,
    parameter int WORDS  = 8,
    localparam int WC    = $clog2(WORDS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_miss,
    input  logic [ADDR_W-1:0] i_miss_addr,
    input  logic              d_miss,
    input  logic [ADDR_W-1:0] d_miss_addr,
    output logic              i_busy,
    output logic              d_busy,
    output logic              fsm_busy,
    output logic              fill_sel,
    output logic              write_data_array,
    output logic [WC-1:0]     write_word,
    output logic [DATA_W-1:0] write_data,
    output logic              write_tag_array,
    output logic [ADDR_W-1:0] fill_line_addr,
    output logic              memory_req,
    output logic [ADDR_W-1:0] memory_address,
    input  logic [DATA_W-1:0] memory_data,
    input  logic              memory_data_valid
);

    // Bytes per word and byte offset width of one whole line.
    localparam int c_BYTES = DATA_W / 8;
    localparam int c_OFF_W = $clog2(WORDS * c_BYTES);

    localparam logic [ADDR_W-1:0] c_LINE_MASK = {ADDR_W{1'b1}} << c_OFF_W;
    localparam logic [ADDR_W-1:0] c_BYTES_A   = ADDR_W'(c_BYTES);
    localparam logic [WC:0]       c_WORDS_R   = (WC + 1)'(WORDS);
    localparam logic [WC:0]       c_REQ_ONE   = (WC + 1)'(1);
    localparam logic [WC-1:0]     c_RET_ONE   = WC'(1);
    localparam logic [WC-1:0]     c_RET_LAST  = WC'(WORDS - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_FILL = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            r_state;
    logic              r_fill_sel;
    logic [ADDR_W-1:0] r_base;
    logic [WC:0]       r_req_cnt;   // one extra bit so WORDS itself means "all issued"
    logic [WC-1:0]     r_ret_cnt;   // wraps back to 0 after the last word

    state_t            w_state_nxt;
    logic              w_fill_sel_nxt;
    logic [ADDR_W-1:0] w_base_nxt;
    logic [WC:0]       w_req_cnt_nxt;
    logic [WC-1:0]     w_ret_cnt_nxt;
    logic              w_req_open;
    logic [ADDR_W-1:0] w_req_offset;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_fill_sel <= 1'b0;
            r_base     <= '0;
            r_req_cnt  <= '0;
            r_ret_cnt  <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_fill_sel <= w_fill_sel_nxt;
            r_base     <= w_base_nxt;
            r_req_cnt  <= w_req_cnt_nxt;
            r_ret_cnt  <= w_ret_cnt_nxt;
        end
    end

    // Byte offset of the next request; truncation to ADDR_W is intended.
    assign w_req_offset = ADDR_W'(r_req_cnt) * c_BYTES_A;
    assign w_req_open   = (r_req_cnt < c_WORDS_R);

    // ------------------------------------------------------------------
    // Next-state and FSM outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt      = r_state;
        w_fill_sel_nxt   = r_fill_sel;
        w_base_nxt       = r_base;
        w_req_cnt_nxt    = r_req_cnt;
        w_ret_cnt_nxt    = r_ret_cnt;
        memory_req       = 1'b0;
        memory_address   = r_base;
        write_data_array = 1'b0;
        write_tag_array  = 1'b0;

        case (r_state)
            S_IDLE: begin
                // Data side has fixed priority; the loser keeps its miss
                // asserted and is picked up after this fill completes.
                if (d_miss) begin
                    w_state_nxt    = S_FILL;
                    w_fill_sel_nxt = 1'b1;
                    w_base_nxt     = d_miss_addr & c_LINE_MASK;
                    w_req_cnt_nxt  = '0;
                    w_ret_cnt_nxt  = '0;
                end else if (i_miss) begin
                    w_state_nxt    = S_FILL;
                    w_fill_sel_nxt = 1'b0;
                    w_base_nxt     = i_miss_addr & c_LINE_MASK;
                    w_req_cnt_nxt  = '0;
                    w_ret_cnt_nxt  = '0;
                end
            end

            S_FILL: begin
                // Request and return sides run independently: returns may
                // overlap with requests still being issued.
                memory_req     = w_req_open;
                memory_address = r_base + w_req_offset;
                if (w_req_open) begin
                    w_req_cnt_nxt = r_req_cnt + c_REQ_ONE;
                end

                write_data_array = memory_data_valid;
                if (memory_data_valid) begin
                    w_ret_cnt_nxt = r_ret_cnt + c_RET_ONE;
                    if (r_ret_cnt == c_RET_LAST) begin
                        w_state_nxt = S_DONE;
                    end
                end
            end

            S_DONE: begin
                write_tag_array = 1'b1;
                w_state_nxt     = S_IDLE;
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Registered-state outputs
    // ------------------------------------------------------------------
    assign fsm_busy       = (r_state != S_IDLE);
    assign fill_sel       = r_fill_sel;
    assign fill_line_addr = r_base;
    assign write_word     = r_ret_cnt;
    assign write_data     = memory_data;

    // The filled channel is released in the tag-write cycle, when its own
    // tag lookup already hits; otherwise the stall follows the miss.
    assign i_busy = i_miss & ~((r_state == S_DONE) & ~r_fill_sel);
    assign d_busy = d_miss & ~((r_state == S_DONE) &  r_fill_sel);

endmodule
`default_nettype wire

// File: tb/tb_cache_fill_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cache_fill_ctrl
//  Purpose  : Self-checking bench for cache_fill_ctrl: vector table,
//             directed multi-cycle sequences and randomized traffic against
//             a transaction-level reference model and a memory model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_cache_fill_ctrl;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 16;
    localparam int WORDS  = 8;
    localparam int WC     = 3;
    localparam int BYTES  = DATA_W / 8;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              i_miss, d_miss;
    logic [ADDR_W-1:0] i_miss_addr, d_miss_addr;
    logic              i_busy, d_busy, fsm_busy, fill_sel;
    logic              write_data_array, write_tag_array, memory_req;
    logic [WC-1:0]     write_word;
    logic [DATA_W-1:0] write_data, memory_data;
    logic [ADDR_W-1:0] fill_line_addr, memory_address;
    logic              memory_data_valid;

    always #5 clk = ~clk;

    cache_fill_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .WORDS(WORDS)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_miss(i_miss), .i_miss_addr(i_miss_addr),
        .d_miss(d_miss), .d_miss_addr(d_miss_addr),
        .i_busy(i_busy), .d_busy(d_busy), .fsm_busy(fsm_busy),
        .fill_sel(fill_sel), .write_data_array(write_data_array),
        .write_word(write_word), .write_data(write_data),
        .write_tag_array(write_tag_array), .fill_line_addr(fill_line_addr),
        .memory_req(memory_req), .memory_address(memory_address),
        .memory_data(memory_data), .memory_data_valid(memory_data_valid)
    );

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Staged stimulus, applied to the DUT at the start of each cycle.
    logic              s_rst_n = 1'b1, s_i_miss = 1'b0, s_d_miss = 1'b0, s_valid = 1'b0;
    logic [ADDR_W-1:0] s_i_addr = '0, s_d_addr = '0;
    logic [DATA_W-1:0] s_data = '0;
    bit                mem_en = 1'b0;     // memory model drives returns
    bit                auto_drop = 1'b1;  // cache drops its miss once tag is written

    // Memory model: in-order returns, latency mem_L, optional gaps.
    typedef struct { int due; logic [DATA_W-1:0] data; } ret_t;
    ret_t mq[$];
    int   last_due = 0;
    int   mem_L = 4, mem_gap = 0;
    bit   mem_gap_rand = 1'b0;

    // Reference model: a fill in progress, then one tag-write cycle.
    bit                m_filling = 1'b0, m_tagging = 1'b0;
    logic              m_sel = 1'b0;
    logic [ADDR_W-1:0] m_base = '0;
    int                m_start = 0, m_rets = 0;

    // Observations.
    int                d_tag_cyc = 0, i_tag_cyc = 0, wr_count = 0, req_count = 0, tag_count = 0;
    logic [ADDR_W-1:0] tag_line = '0;

    function automatic logic [DATA_W-1:0] data_of(input logic [ADDR_W-1:0] a);
        logic [DATA_W-1:0] t;
        t = a * 16'h9E37;
        return t ^ 16'h5A3C;
    endfunction

    function automatic logic [ADDR_W-1:0] line_of(input logic [ADDR_W-1:0] a);
        return ADDR_W'((int'(a) / (WORDS * BYTES)) * (WORDS * BYTES));
    endfunction

    task automatic tick();
        logic [ADDR_W-1:0] ea;
        logic [DATA_W-1:0] ed;
        logic              exp_req;
        int                due, gap;
        @(negedge clk);
        rst_n = s_rst_n; i_miss = s_i_miss; d_miss = s_d_miss;
        i_miss_addr = s_i_addr; d_miss_addr = s_d_addr;
        if (mem_en) begin
            if (mq.size() > 0 && mq[0].due <= cyc) begin
                memory_data_valid = 1'b1; memory_data = mq[0].data;
                void'(mq.pop_front());
            end else begin
                memory_data_valid = 1'b0; memory_data = '0;
            end
        end else begin
            memory_data_valid = s_valid; memory_data = s_data;
        end
        #1;
        exp_req = m_filling && ((cyc - m_start) < WORDS);
        chk("fsm_busy", fsm_busy, m_filling || m_tagging);
        chk("memory_req", memory_req, exp_req);
        if (exp_req) begin
            ea = ADDR_W'(int'(m_base) + (cyc - m_start) * BYTES);
            chk("memory_address", memory_address, ea);
        end else if (!m_filling) begin
            chk("memory_address_idle", memory_address, m_base);
        end
        chk("write_data_array", write_data_array, m_filling && memory_data_valid);
        if (m_filling && memory_data_valid) begin
            chk("write_word", write_word, m_rets);
            if (mem_en) begin
                ed = data_of(ADDR_W'(int'(m_base) + m_rets * BYTES));
                chk("write_data", write_data, ed);
            end
        end
        if (!m_filling) chk("write_word_idle", write_word, 0);
        chk("write_tag_array", write_tag_array, m_tagging);
        chk("fill_sel", fill_sel, m_sel);
        chk("fill_line_addr", fill_line_addr, m_base);
        chk("i_busy", i_busy, i_miss && !(m_tagging && m_sel == 1'b0));
        chk("d_busy", d_busy, d_miss && !(m_tagging && m_sel == 1'b1));

        if (write_data_array) wr_count++;
        if (memory_req) req_count++;
        if (write_tag_array) begin
            tag_count++;
            tag_line = fill_line_addr;
            if (fill_sel) d_tag_cyc = cyc; else i_tag_cyc = cyc;
            if (auto_drop) begin
                if (fill_sel) s_d_miss = 1'b0; else s_i_miss = 1'b0;
            end
        end
        if (mem_en && memory_req && rst_n) begin
            gap = mem_gap_rand ? int'($urandom_range(0, mem_gap)) : mem_gap;
            due = cyc + mem_L;
            if (due < last_due + 1 + gap) due = last_due + 1 + gap;
            last_due = due;
            mq.push_back('{due: due, data: data_of(memory_address)});
        end

        // Model advances on the clock edge with this cycle's inputs.
        if (!rst_n) begin
            m_filling = 1'b0; m_tagging = 1'b0; m_sel = 1'b0; m_base = '0; m_rets = 0;
            mq.delete(); last_due = 0;
        end else if (m_tagging) begin
            m_tagging = 1'b0;
        end else if (m_filling) begin
            if (memory_data_valid) begin
                m_rets++;
                if (m_rets == WORDS) begin m_filling = 1'b0; m_tagging = 1'b1; end
            end
        end else if (d_miss || i_miss) begin
            m_filling = 1'b1; m_sel = d_miss; m_rets = 0; m_start = cyc + 1;
            m_base = line_of(d_miss ? d_miss_addr : i_miss_addr);
        end
        cyc++;
    endtask

    task automatic run_until_idle(input int max_cycles);
        int n = 0;
        do begin
            tick(); n++;
        end while ((m_filling || m_tagging || s_i_miss || s_d_miss) && n < max_cycles);
        if (m_filling || m_tagging || s_i_miss || s_d_miss) begin
            n_checks++; n_errors++;
            $display("FAIL run_until_idle: still busy after %0d cycles (cycle %0d)", max_cycles, cyc);
        end
    endtask

    typedef struct {
        logic rst_n, im, dm, v;
        logic fb, ib, db, wda, tag, req;
    } vec_t;
    vec_t tbl[12];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int T, wr0, rq0, n;

        //             rst im dm v    fb ib db wda tag req
        tbl[0]  = '{1, 0, 0, 1,   0, 0, 0, 0, 0, 0};
        tbl[1]  = '{1, 1, 0, 0,   0, 1, 0, 0, 0, 0};
        tbl[2]  = '{1, 1, 0, 0,   1, 1, 0, 0, 0, 1};
        tbl[3]  = '{0, 1, 0, 0,   1, 1, 0, 0, 0, 1};
        tbl[4]  = '{1, 1, 0, 0,   0, 1, 0, 0, 0, 0};
        tbl[5]  = '{1, 0, 0, 0,   1, 0, 0, 0, 0, 1};
        tbl[6]  = '{0, 0, 0, 0,   1, 0, 0, 0, 0, 1};
        tbl[7]  = '{1, 0, 0, 1,   0, 0, 0, 0, 0, 0};
        tbl[8]  = '{1, 0, 1, 0,   0, 0, 1, 0, 0, 0};
        tbl[9]  = '{0, 0, 1, 1,   1, 0, 1, 1, 0, 1};
        tbl[10] = '{1, 0, 0, 1,   0, 0, 0, 0, 0, 0};
        tbl[11] = '{1, 0, 0, 0,   0, 0, 0, 0, 0, 0};

        // Initial reset before any checking.
        rst_n = 1'b0; i_miss = 1'b0; d_miss = 1'b0; i_miss_addr = '0; d_miss_addr = '0;
        memory_data = '0; memory_data_valid = 1'b0;
        repeat (2) @(posedge clk);

        // Vector table: reset, valid-in-idle, mid-fill resets.
        mem_en = 1'b0;
        s_i_addr = 16'h0456; s_d_addr = 16'h0E10;
        for (int i = 0; i < 12; i++) begin
            s_rst_n = tbl[i].rst_n; s_i_miss = tbl[i].im; s_d_miss = tbl[i].dm;
            s_valid = tbl[i].v; s_data = DATA_W'($urandom);
            tick();
            chk($sformatf("tbl[%0d].fsm_busy", i), fsm_busy, tbl[i].fb);
            chk($sformatf("tbl[%0d].i_busy", i), i_busy, tbl[i].ib);
            chk($sformatf("tbl[%0d].d_busy", i), d_busy, tbl[i].db);
            chk($sformatf("tbl[%0d].write_data_array", i), write_data_array, tbl[i].wda);
            chk($sformatf("tbl[%0d].write_tag_array", i), write_tag_array, tbl[i].tag);
            chk($sformatf("tbl[%0d].memory_req", i), memory_req, tbl[i].req);
        end
        s_rst_n = 1'b1; s_i_miss = 1'b0; s_d_miss = 1'b0; s_valid = 1'b0;
        mem_en = 1'b1;
        tick();

        // A: basic data fill, latency 4.
        mem_L = 4; mem_gap = 0; mem_gap_rand = 1'b0;
        s_d_miss = 1'b1; s_d_addr = 16'h1236;
        T = cyc; wr0 = wr_count; rq0 = req_count;
        run_until_idle(100);
        chk("A_tag_latency", d_tag_cyc - T, WORDS + mem_L + 1);
        chk("A_writes", wr_count - wr0, WORDS);
        chk("A_requests", req_count - rq0, WORDS);
        chk("A_line", tag_line, 16'h1230);
        tick();

        // B: simultaneous misses, data first, instruction right after.
        mem_L = 2;
        s_d_miss = 1'b1; s_d_addr = 16'h0F0F; s_i_miss = 1'b1; s_i_addr = 16'hA0A1;
        T = cyc;
        run_until_idle(200);
        chk("B_d_tag_latency", d_tag_cyc - T, WORDS + mem_L + 1);
        chk("B_i_after_d", i_tag_cyc - d_tag_cyc, WORDS + mem_L + 2);
        tick();

        // C: latency 1 with three idle cycles between returns.
        mem_L = 1; mem_gap = 3;
        s_i_miss = 1'b1; s_i_addr = 16'h4A5F;
        T = cyc; wr0 = wr_count;
        run_until_idle(200);
        chk("C_writes", wr_count - wr0, WORDS);
        chk("C_tag_latency", i_tag_cyc - T, 2 + (WORDS - 1) * 4 + 1);
        repeat (3) tick();
        chk("C_no_extra_writes", wr_count - wr0, WORDS);

        // D: reset after three words, then a fresh instruction fill.
        mem_L = 2; mem_gap = 0;
        s_d_miss = 1'b1; s_d_addr = 16'h7770;
        wr0 = wr_count; n = 0;
        while (wr_count - wr0 < 3 && n < 100) begin tick(); n++; end
        chk("D_three_words_seen", wr_count - wr0, 3);
        s_rst_n = 1'b0; s_d_miss = 1'b0;
        tick();
        s_rst_n = 1'b1;
        tick();
        chk("D_reset_fsm_busy", fsm_busy, 0);
        chk("D_reset_req", memory_req, 0);
        chk("D_reset_line", fill_line_addr, 0);
        chk("D_reset_addr", memory_address, 0);
        s_i_miss = 1'b1; s_i_addr = 16'h0102;
        wr0 = wr_count;
        run_until_idle(100);
        chk("D_refill_writes", wr_count - wr0, WORDS);
        tick();

        // E: address change and instruction miss during a data fill.
        mem_L = 3;
        s_d_miss = 1'b1; s_d_addr = 16'h2222;
        repeat (3) tick();
        s_d_addr = 16'hFFFF; s_i_miss = 1'b1; s_i_addr = 16'h3330;
        run_until_idle(200);
        chk("E_order", i_tag_cyc > d_tag_cyc, 1);
        chk("E_i_line", tag_line, 16'h3330);
        tick();

        // Randomized traffic with occasional resets.
        mem_gap = 2; mem_gap_rand = 1'b1;
        for (int k = 0; k < 1500; k++) begin
            if (k % 40 == 0) mem_L = $urandom_range(1, 5);
            if (!s_i_miss && $urandom_range(0, 9) == 0) begin
                s_i_miss = 1'b1; s_i_addr = ADDR_W'($urandom);
            end
            if (!s_d_miss && $urandom_range(0, 11) == 0) begin
                s_d_miss = 1'b1; s_d_addr = ADDR_W'($urandom);
            end
            if ($urandom_range(0, 15) == 0) s_d_addr = ADDR_W'($urandom);
            s_rst_n = ($urandom_range(0, 299) != 0);
            tick();
        end
        s_rst_n = 1'b1;
        run_until_idle(500);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/cache_fill_ctrl.md
# cache_fill_ctrl

Parametrised, two-channel cache line fill controller between the instruction cache, the data cache, and the shared pipelined main memory. On a miss from either cache it latches the line address and issues one read request per word with consecutive word addresses. It writes each returning word into the selected cache's data array, then pulses the tag write. Data misses have fixed priority over instruction misses; a per-channel busy output stalls the pipeline.

## Interface
- ADDR_W, 16, address width (bits)
- DATA_W, 16, word width; memory addresses are byte addresses, one word = DATA_W/8 bytes
- WORDS, 8, words per cache line; power of 2, ≥2; WC = log2(WORDS)
- clk  in  1  clock; all state changes on rising edge
- rst_n  in  1  reset, synchronous, active-low
- i_miss  in  1  instruction-cache miss (held until tag lookup hits)
- i_miss_addr  in  ADDR_W  instruction miss address
- d_miss  in  1  data-cache miss (held until tag lookup hits)
- d_miss_addr  in  ADDR_W  data miss address
- i_busy  out  1  stall for instruction side
- d_busy  out  1  stall for data side
- fsm_busy  out  1  high whenever state ≠ IDLE
- fill_sel  out  1  cache being filled: 0 = I, 1 = D
- write_data_array  out  1  data-array write enable for the fill_sel cache
- write_word  out  WC  word index within the line being written
- write_data  out  DATA_W  word to write; equals memory_data
- write_tag_array  out  1  tag-array write enable, one-cycle pulse
- fill_line_addr  out  ADDR_W  latched line-aligned address; used for tag/index
- memory_req  out  1  read request; memory accepts one request per cycle
- memory_address  out  ADDR_W  request byte address
- memory_data  in  DATA_W  returned word
- memory_data_valid  in  1  memory_data valid; returns arrive in request order

## Operation
- States: IDLE, FILL, DONE. Registers: state, fill_sel, line base (ADDR_W), req_cnt (WC+1 bits), ret_cnt (WC bits).
- Line base = miss address with its low log2(WORDS·DATA_W/8) bits cleared.
- IDLE:
  - If d_miss: latch d_miss_addr line base, fill_sel←1, go to FILL.
  - Else if i_miss: latch the I address, fill_sel←0, go to FILL.
  - Else stay in IDLE.
  - On entry to FILL, clear req_cnt and ret_cnt.
- FILL, request side:
  - memory_req = (req_cnt < WORDS).
  - memory_address = base + req_cnt·(DATA_W/8), truncated to ADDR_W.
  - req_cnt increments each cycle memory_req is high.
- FILL, return side:
  - write_data_array = memory_data_valid; write_word = ret_cnt.
  - ret_cnt increments on each valid.
  - Valid with ret_cnt = WORDS−1 → DONE.
- DONE: write_tag_array = 1 for exactly one cycle, then → IDLE.
- Outside FILL, memory_req = 0, write_data_array = 0, and memory_address = base.
- memory_data_valid is ignored in IDLE and DONE.
- Miss inputs and addresses are ignored outside IDLE. The latched address is not affected by changes mid-fill.
- x_busy (x ∈ {i, d}) = x_miss AND NOT (state = DONE AND fill_sel = x).
  - The losing channel in a simultaneous miss stays busy until its own fill completes.
  - In the DONE cycle the filled channel sees busy = 0 while its lookup hits.
- Reset (rst_n = 0 at an edge), including mid-fill:
  - state = IDLE, counters = 0, fill_sel = 0, base = 0.
  - All outputs are 0 after the edge, except x_busy, which follows x_miss.
  - Memory is reset together with this block, so no stale returns occur.

## Timing
- Miss seen in IDLE at cycle T. FILL starts at T+1. memory_req is high for cycles T+1 … T+WORDS.
- For memory latency L (valid L cycles after its request), the last write is at T+WORDS+L and write_tag_array at T+WORDS+L+1. IDLE is entered at T+WORDS+L+2, so back-to-back fills are separated by one idle cycle.
- Returns may arrive while requests are still issuing; L = 1 is supported.
- Gaps in memory_data_valid are legal and stall ret_cnt only.
- write_* outputs are combinational from the registered state and memory_data_valid. There is no added latency from memory to the array.

## Test plan
- Reset, then d_miss, d_miss_addr=0x1236, WORDS=8, L=4 → requests 0x1230, 0x1232, …, 0x123E on 8 consecutive cycles. write_word 0…7 tracks returns; write_tag_array pulses once at T+13; fill_line_addr=0x1230.
- i_miss and d_miss both rise at the same cycle → D fill first (fill_sel=1) with i_busy held high throughout. The I fill starts in the cycle after D returns to IDLE.
- Valid returns with 3-cycle gaps between words → writes occur only on valid cycles. Tag pulse follows the 8th word; no extra writes.
- rst_n low for one cycle mid-FILL after 3 words → all outputs 0 next cycle and state IDLE. A new i_miss restarts from word 0.
- d_miss_addr changed and i_miss raised mid-fill → memory_address sequence unchanged and fill_sel unchanged. i_busy is high; the I fill follows.
- memory_data_valid pulsed while in IDLE → no write_data_array or write_tag_array activity.
